// File: rtl/pcileech_tlp_pkg.sv
// Shared TLP stream types and limits for the PCIe TX path.
// Used by the TX arbiter and its skid buffer.
package pcileech_tlp_pkg;

    localparam int TLP_DATA_W    = 64;
    localparam int TLP_KEEP_W    = 2;
    localparam int TXARB_MAX_SRC = 4;

    typedef struct packed {
        logic [TLP_DATA_W-1:0] data;
        logic [TLP_KEEP_W-1:0] keep;
        logic                  last;
    } tlp_beat_t;

    typedef enum logic [1:0] {
        TXARB_IDLE = 2'd0,
        TXARB_BUSY = 2'd1,
        TXARB_DROP = 2'd2
    } txarb_state_t;

endpackage

// File: rtl/pcileech_tlp_skid.sv
// Two-entry registered skid buffer for TLP beats; output is always driven from
// storage, so a beat appears downstream one cycle after it is accepted.
module pcileech_tlp_skid
    import pcileech_tlp_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      in_valid,
    output logic      in_ready,
    input  tlp_beat_t in_beat,
    output logic      out_valid,
    input  logic      out_ready,
    output tlp_beat_t out_beat,
    output logic      full
);

    tlp_beat_t  mem [2];
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       push;
    logic       pop;

    assign full      = (count == 2'd2);
    assign in_ready  = ~full;
    assign out_valid = (count != 2'd0);
    assign out_beat  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pcileech_tlp_tx_arb.sv
// Packet-atomic round-robin arbiter sharing the PCIe core TX stream between requesters.
// Optional PCILEECH_TXARB_STATS_EN adds per-source packet counters and a stall counter.
module pcileech_tlp_tx_arb
    import pcileech_tlp_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int MAX_BEATS = 66
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    link_up,
    input  logic [64*NUM_SRC-1:0]   s_tdata,
    input  logic [2*NUM_SRC-1:0]    s_tkeep,
    input  logic [NUM_SRC-1:0]      s_tlast,
    input  logic [NUM_SRC-1:0]      s_tvalid,
    output logic [NUM_SRC-1:0]      s_tready,
    output logic [63:0]             m_tdata,
    output logic [1:0]              m_tkeep,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [1:0]              grant_idx,
    output logic                    busy,
    output logic                    err_oversize,
`ifdef PCILEECH_TXARB_STATS_EN
    output logic [NUM_SRC*16-1:0]   stat_pkts,
    output logic [15:0]             stat_stall,
`endif
    input  logic                    err_clr
);

    txarb_state_t state;
    txarb_state_t state_next;
    logic [1:0]   grant_next;
    logic [1:0]   rr_idx;
    logic         rr_found;
    logic [6:0]   beat_cnt;
    logic [6:0]   cnt_next;
    logic         at_max;
    logic         err_set;
    logic         sel_valid;
    tlp_beat_t    sel_beat;
    tlp_beat_t    skid_in_beat;
    tlp_beat_t    skid_out_beat;
    logic         skid_in_valid;
    logic         skid_in_ready;
    logic         skid_out_valid;
    logic         skid_full;

    assign at_max = (beat_cnt == 7'(MAX_BEATS - 1));
    assign busy   = (state != TXARB_IDLE);

    always_comb begin
        sel_valid = 1'b0;
        sel_beat  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant_idx == 2'(k)) begin
                sel_valid     = s_tvalid[k];
                sel_beat.data = s_tdata[64*k +: 64];
                sel_beat.keep = s_tkeep[2*k +: 2];
                sel_beat.last = s_tlast[k];
            end
        end
    end

    // Search starts one past the last grant so every requester gets a turn per packet.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = grant_idx;
        for (int i = 1; i <= NUM_SRC; i++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (!rr_found && s_tvalid[k] && (k == (int'(grant_idx) + i) % NUM_SRC)) begin
                    rr_found = 1'b1;
                    rr_idx   = 2'(k);
                end
            end
        end
    end

    always_comb begin
        state_next         = state;
        grant_next         = grant_idx;
        cnt_next           = beat_cnt;
        err_set            = 1'b0;
        s_tready           = '0;
        skid_in_valid      = 1'b0;
        skid_in_beat       = sel_beat;
        skid_in_beat.last  = sel_beat.last | at_max;
        case (state)
            TXARB_IDLE: begin
                if (link_up && rr_found) begin
                    grant_next = rr_idx;
                    state_next = TXARB_BUSY;
                end
            end
            TXARB_BUSY: begin
                skid_in_valid = sel_valid;
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (grant_idx == 2'(k)) begin
                        s_tready[k] = ~skid_full;
                    end
                end
                if (sel_valid && skid_in_ready) begin
                    if (sel_beat.last) begin
                        state_next = TXARB_IDLE;
                        cnt_next   = 7'd0;
                    end else if (at_max) begin
                        state_next = TXARB_DROP;
                        cnt_next   = 7'd0;
                        err_set    = 1'b1;
                    end else begin
                        cnt_next = beat_cnt + 7'd1;
                    end
                end
            end
            TXARB_DROP: begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (grant_idx == 2'(k)) begin
                        s_tready[k] = 1'b1;
                    end
                end
                if (sel_valid && sel_beat.last) begin
                    state_next = TXARB_IDLE;
                end
            end
            default: begin
                state_next = TXARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= TXARB_IDLE;
            grant_idx    <= 2'(NUM_SRC - 1);
            beat_cnt     <= 7'd0;
            err_oversize <= 1'b0;
        end else begin
            state        <= state_next;
            grant_idx    <= grant_next;
            beat_cnt     <= cnt_next;
            err_oversize <= err_set | (err_oversize & ~err_clr);
        end
    end

    pcileech_tlp_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .in_beat   (skid_in_beat),
        .out_valid (skid_out_valid),
        .out_ready (m_tready),
        .out_beat  (skid_out_beat),
        .full      (skid_full)
    );

    assign m_tvalid = skid_out_valid;
    assign m_tdata  = skid_out_beat.data;
    assign m_tkeep  = skid_out_beat.keep;
    assign m_tlast  = skid_out_beat.last;

`ifdef PCILEECH_TXARB_STATS_EN
    // The grant may move on while a packet tail still sits in the skid buffer,
    // so the owning source travels alongside each buffered beat.
    logic [1:0] src_q [2];
    logic       src_wr;
    logic       src_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q[0]   <= 2'd0;
            src_q[1]   <= 2'd0;
            src_wr     <= 1'b0;
            src_rd     <= 1'b0;
            stat_pkts  <= '0;
            stat_stall <= 16'd0;
        end else begin
            if (skid_in_valid && skid_in_ready) begin
                src_q[src_wr] <= grant_idx;
                src_wr        <= ~src_wr;
            end
            if (m_tvalid && m_tready) begin
                src_rd <= ~src_rd;
            end
            if (err_clr) begin
                stat_pkts  <= '0;
                stat_stall <= 16'd0;
            end else begin
                if (m_tvalid && m_tready && m_tlast) begin
                    for (int k = 0; k < NUM_SRC; k++) begin
                        if (src_q[src_rd] == 2'(k)) begin
                            stat_pkts[16*k +: 16] <= stat_pkts[16*k +: 16] + 16'd1;
                        end
                    end
                end
                if (m_tvalid && !m_tready && (stat_stall != 16'hFFFF)) begin
                    stat_stall <= stat_stall + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pcileech_tlp_tx_arb.sv
// Scoreboard bench for the TLP TX arbiter: expected beats are queued on acceptance
// at the sources and matched in order against the master stream.
module tb_pcileech_tlp_tx_arb;

    localparam int NUM_SRC   = 2;
    localparam int MAX_BEATS = 66;

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  k;
        logic        l;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  link_up;
    logic [63:0]           sd [NUM_SRC];
    logic [1:0]            sk [NUM_SRC];
    logic [NUM_SRC-1:0]    sl;
    logic [NUM_SRC-1:0]    sv;
    logic [64*NUM_SRC-1:0] s_tdata;
    logic [2*NUM_SRC-1:0]  s_tkeep;
    logic [NUM_SRC-1:0]    s_tready;
    logic [63:0]           m_tdata;
    logic [1:0]            m_tkeep;
    logic                  m_tlast;
    logic                  m_tvalid;
    logic                  m_tready;
    logic [1:0]            grant_idx;
    logic                  busy;
    logic                  err_oversize;
    logic                  err_clr;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   out_beats = 0;
    int   first_out_cyc = 0;
    int   last_tlast_cyc = 0;
    bit   mon_first_pending = 1'b0;
    bit   mon_prev_stall = 1'b0;
    logic [66:0] mon_prev = '0;
    bit   in_pkt = 1'b0;
    logic [7:0] cur_src = '0;
    exp_t sb [$];
    int   pkt_src_log [$];

    always_comb begin
        s_tdata = '0;
        s_tkeep = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            s_tdata[64*k +: 64] = sd[k];
            s_tkeep[2*k +: 2]   = sk[k];
        end
    end

    pcileech_tlp_tx_arb #(.NUM_SRC(NUM_SRC), .MAX_BEATS(MAX_BEATS)) dut (
        .clk          (clk),
        .rst          (rst),
        .link_up      (link_up),
        .s_tdata      (s_tdata),
        .s_tkeep      (s_tkeep),
        .s_tlast      (sl),
        .s_tvalid     (sv),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tkeep      (m_tkeep),
        .m_tlast      (m_tlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .err_oversize (err_oversize),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: in-order scoreboard match, stall hold and packet contiguity.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mon_prev_stall = 1'b0;
        end else begin
            if (mon_prev_stall) begin
                checks++;
                if (!m_tvalid || ({m_tdata, m_tkeep, m_tlast} !== mon_prev)) begin
                    failures++;
                    $display("[TB] FAIL stall_hold: got valid=%0b beat=%h required beat=%h", m_tvalid, {m_tdata, m_tkeep, m_tlast}, mon_prev);
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL out_beat: got unexpected beat %h, required none", {m_tdata, m_tkeep, m_tlast});
                end else begin
                    e = sb.pop_front();
                    if ({m_tdata, m_tkeep, m_tlast} !== {e.d, e.k, e.l}) begin
                        failures++;
                        $display("[TB] FAIL out_beat: got %h required %h", {m_tdata, m_tkeep, m_tlast}, {e.d, e.k, e.l});
                    end
                end
                if (in_pkt) begin
                    checks++;
                    if (m_tdata[63:56] !== cur_src) begin
                        failures++;
                        $display("[TB] FAIL interleave: got src %0d required src %0d", m_tdata[63:56], cur_src);
                    end
                end
                in_pkt  = !m_tlast;
                cur_src = m_tdata[63:56];
                if (mon_first_pending) begin
                    first_out_cyc     = cyc;
                    mon_first_pending = 1'b0;
                end
                out_beats++;
                if (m_tlast) begin
                    last_tlast_cyc = cyc;
                    pkt_src_log.push_back(int'(m_tdata[63:56]));
                end
            end
            mon_prev_stall = m_tvalid && !m_tready;
            mon_prev       = {m_tdata, m_tkeep, m_tlast};
        end
    end

    task automatic send_beat(input int src, input int pkt, input int beat, input logic last,
                             input bit fwd, input bit fwd_last);
        int waited = 0;
        sd[src] = {8'(src), 8'(pkt), 16'(beat), 32'($urandom())};
        sk[src] = 2'($urandom_range(1, 3));
        sl[src] = last;
        sv[src] = 1'b1;
        @(negedge clk);
        while (!s_tready[src] && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!s_tready[src]) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: src %0d beat %0d got no s_tready, required accept", src, beat);
            sv[src] = 1'b0;
            sl[src] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (fwd) sb.push_back({sd[src], sk[src], fwd_last});
        sv[src] = 1'b0;
        sl[src] = 1'b0;
    endtask

    task automatic send_pkt(input int src, input int pkt, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            send_beat(src, pkt, b, (b == nbeats - 1), (b < MAX_BEATS),
                      (b == nbeats - 1) || (b == MAX_BEATS - 1));
        end
    endtask

    task automatic drain(output bit ok);
        int w = 0;
        while ((sb.size() != 0 || busy || m_tvalid) && w < 400) begin
            @(negedge clk);
            w++;
        end
        ok = (sb.size() == 0) && !busy && !m_tvalid;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        link_up  = 1'b1;
        m_tready = 1'b1;
        err_clr  = 1'b0;
        sl       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sd[k] = 64'h0;
            sk[k] = 2'b11;
        end
        sv = '1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (s_tready !== '0) begin failures++; $display("[TB] FAIL reset_tready: got %b required 0", s_tready); end
        if (m_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_mvalid: got %b required 0", m_tvalid); end
        if (grant_idx !== 2'(NUM_SRC - 1)) begin failures++; $display("[TB] FAIL reset_grant: got %0d required %0d", grant_idx, NUM_SRC - 1); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        if (err_oversize !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b required 0", err_oversize); end
        if ({m_tdata, m_tkeep, m_tlast} !== 67'h0) begin failures++; $display("[TB] FAIL reset_mdata: got %h required 0", {m_tdata, m_tkeep, m_tlast}); end
        sv = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int start;
        int base;
        bit ok;
        @(posedge clk);
        #1;
        base              = out_beats;
        start             = cyc;
        mon_first_pending = 1'b1;
        send_pkt(0, 1, 3);
        drain(ok);
        checks += 4;
        if (!ok) begin failures++; $display("[TB] FAIL single_drain: got busy=%b pending=%0d required idle", busy, sb.size()); end
        if (first_out_cyc != start + 2) begin failures++; $display("[TB] FAIL single_latency: got cycle %0d required %0d", first_out_cyc, start + 2); end
        if (last_tlast_cyc != first_out_cyc + 2) begin failures++; $display("[TB] FAIL single_contig: got tlast cycle %0d required %0d", last_tlast_cyc, first_out_cyc + 2); end
        if (out_beats - base != 3) begin failures++; $display("[TB] FAIL single_count: got %0d required 3", out_beats - base); end
    endtask

    task automatic test_fairness();
        bit ok;
        pkt_src_log.delete();
        @(posedge clk);
        #1;
        fork
            begin
                for (int p = 0; p < 4; p++) send_pkt(0, 10 + p, 2);
            end
            begin
                for (int p = 0; p < 4; p++) send_pkt(1, 20 + p, 2);
            end
        join
        drain(ok);
        checks += 2;
        if (!ok) begin failures++; $display("[TB] FAIL fair_drain: got busy=%b pending=%0d required idle", busy, sb.size()); end
        if (pkt_src_log.size() != 8) begin failures++; $display("[TB] FAIL fair_pkts: got %0d required 8", pkt_src_log.size()); end
        for (int i = 0; i < pkt_src_log.size(); i++) begin
            checks++;
            if (pkt_src_log[i] != (i + 1) % 2) begin
                failures++;
                $display("[TB] FAIL fair_order[%0d]: got src %0d required src %0d", i, pkt_src_log[i], (i + 1) % 2);
            end
        end
    endtask

    task automatic test_oversize();
        int base;
        bit ok;
        checks++;
        if (err_oversize !== 1'b0) begin failures++; $display("[TB] FAIL ovs_pre: got %b required 0", err_oversize); end
        base = out_beats;
        send_pkt(1, 30, 70);
        drain(ok);
        repeat (3) @(negedge clk);
        checks += 4;
        if (!ok) begin failures++; $display("[TB] FAIL ovs_drain: got busy=%b pending=%0d required idle", busy, sb.size()); end
        if (out_beats - base != MAX_BEATS) begin failures++; $display("[TB] FAIL ovs_count: got %0d required %0d", out_beats - base, MAX_BEATS); end
        if (err_oversize !== 1'b1) begin failures++; $display("[TB] FAIL ovs_err_set: got %b required 1", err_oversize); end
        if (grant_idx !== 2'd1) begin failures++; $display("[TB] FAIL ovs_grant: got %0d required 1", grant_idx); end
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (err_oversize !== 1'b0) begin failures++; $display("[TB] FAIL ovs_err_clr: got %b required 0", err_oversize); end
    endtask

    task automatic test_backpressure();
        int base;
        bit done = 1'b0;
        bit ok;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        base = out_beats;
        @(posedge clk);
        #1;
        fork
            begin
                send_pkt(0, 40, 5);
                done = 1'b1;
            end
            begin
                int i = 0;
                while (!done) begin
                    m_tready = pat[i % 4];
                    i++;
                    @(posedge clk);
                    #1;
                end
            end
        join
        m_tready = 1'b1;
        drain(ok);
        checks += 2;
        if (!ok) begin failures++; $display("[TB] FAIL bp_drain: got busy=%b pending=%0d required idle", busy, sb.size()); end
        if (out_beats - base != 5) begin failures++; $display("[TB] FAIL bp_count: got %0d required 5", out_beats - base); end
    endtask

    task automatic test_link_drop();
        int base;
        bit ok;
        base = out_beats;
        pkt_src_log.delete();
        send_beat(0, 50, 0, 1'b0, 1'b1, 1'b0);
        send_beat(0, 50, 1, 1'b0, 1'b1, 1'b0);
        link_up = 1'b0;
        sd[1]   = {8'd1, 8'd51, 16'd0, 32'h0};
        sk[1]   = 2'b11;
        sl[1]   = 1'b0;
        sv[1]   = 1'b1;
        send_beat(0, 50, 2, 1'b0, 1'b1, 1'b0);
        send_beat(0, 50, 3, 1'b1, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
        checks += 4;
        if (out_beats - base != 4) begin failures++; $display("[TB] FAIL link_complete: got %0d beats required 4", out_beats - base); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL link_busy: got %b required 0", busy); end
        if (s_tready[1] !== 1'b0) begin failures++; $display("[TB] FAIL link_nogrant: got tready %b required 0", s_tready[1]); end
        if (grant_idx !== 2'd0) begin failures++; $display("[TB] FAIL link_grant: got %0d required 0", grant_idx); end
        @(posedge clk);
        #1;
        link_up = 1'b1;
        send_pkt(1, 51, 2);
        drain(ok);
        checks += 3;
        if (!ok) begin failures++; $display("[TB] FAIL link_drain: got busy=%b pending=%0d required idle", busy, sb.size()); end
        if (out_beats - base != 6) begin failures++; $display("[TB] FAIL link_total: got %0d beats required 6", out_beats - base); end
        if (pkt_src_log.size() != 2 || pkt_src_log[pkt_src_log.size() - 1] != 1) begin
            failures++;
            $display("[TB] FAIL link_resume: got %0d packets required 2 ending with src 1", pkt_src_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_oversize();
        test_backpressure();
        test_link_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
